addr4u_result_checker: RTL and testbench

//  Sequential checker directly downstream of the unsigned 4-bit adder. It captures each operand pair
//  and the adder's O[4:0] result and computes a golden A+B. Mismatches are flagged per transaction,

---
 rtl/addr4u_pkg.sv | 10 +
 rtl/addr4u_golden.sv | 12 +
 rtl/addr4u_result_checker.sv | 102 ++++++++++
 tb/tb_addr4u_result_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addr4u_pkg.sv
// Shared types and constants for the 4-bit adder result checker.
package addr4u_pkg;

    localparam int ADDR4U_W = 4;

    typedef enum logic {CHK_RUN, CHK_HALT} chk_state_t;

    typedef logic [ADDR4U_W:0] addr4u_sum_t;

endpackage

// File: rtl/addr4u_golden.sv
// Combinational W+1-bit reference adder; isolated so fault-injection flows can exclude it.
module addr4u_golden #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/addr4u_result_checker.sv
// Checks each adder result against a golden sum, counts mismatches and optionally halts.
// Optional sticky per-bit error map enabled by macro ADDR4U_CHK_BITMAP_EN.
module addr4u_result_checker
    import addr4u_pkg::*;
#(
    parameter int unsigned W     = ADDR4U_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_sum,
    input  logic             halt_on_err,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             halted
`ifdef ADDR4U_CHK_BITMAP_EN
    ,
    output logic [W:0]       err_bitmap
`endif
);

    chk_state_t state_q;
    logic [W:0] golden;
    logic [W:0] diff;
    logic       mismatch;
    logic       accept;

    addr4u_golden #(
        .W(W)
    ) u_golden (
        .a   (in_a),
        .b   (in_b),
        .sum (golden)
    );

    assign diff     = in_sum ^ golden;
    assign mismatch = |diff;
    assign halted   = (state_q == CHK_HALT);

    // clr blocks accepts so a counter clear never races a counter increment.
    assign in_ready = (state_q == CHK_RUN) & ~clr & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CHK_RUN;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            txn_cnt    <= '0;
            err_cnt    <= '0;
`ifdef ADDR4U_CHK_BITMAP_EN
            err_bitmap <= '0;
`endif
        end else begin
            // Output register: the pending result drains independently of clr.
            if (accept) begin
                out_valid <= 1'b1;
                out_sum   <= in_sum;
                out_err   <= mismatch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                state_q    <= CHK_RUN;
                err_sticky <= 1'b0;
                txn_cnt    <= '0;
                err_cnt    <= '0;
`ifdef ADDR4U_CHK_BITMAP_EN
                err_bitmap <= '0;
`endif
            end else if (accept) begin
                txn_cnt <= txn_cnt + 1'b1;
`ifdef ADDR4U_CHK_BITMAP_EN
                err_bitmap <= err_bitmap | diff;
`endif
                if (mismatch) begin
                    err_sticky <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (halt_on_err) begin
                        state_q <= CHK_HALT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_addr4u_result_checker.sv
// Self-checking bench for addr4u_result_checker (CNT_W=4 so wrap and saturation are reachable).
module tb_addr4u_result_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [4:0] in_sum;
    logic       halt_on_err;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic       out_err;
    logic       err_sticky;
    logic [3:0] txn_cnt;
    logic [3:0] err_cnt;
    logic       halted;
`ifdef ADDR4U_CHK_BITMAP_EN
    logic [4:0] err_bitmap;
`endif

    addr4u_result_checker #(
        .W     (4),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sum      (in_sum),
        .halt_on_err (halt_on_err),
        .clr         (clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_err     (out_err),
        .err_sticky  (err_sticky),
        .txn_cnt     (txn_cnt),
        .err_cnt     (err_cnt),
        .halted      (halted)
`ifdef ADDR4U_CHK_BITMAP_EN
        ,
        .err_bitmap  (err_bitmap)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: plain integers and flags.
    int   m_txn;
    int   m_ecnt;
    bit   m_sticky;
    bit   m_halt;
    bit   m_ov;
    bit   m_err;
    int   m_sum;
    int   m_bmap;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic       exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txn = 0; m_ecnt = 0; m_sticky = 0; m_halt = 0;
        m_ov = 0; m_err = 0; m_sum = 0; m_bmap = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] s, input logic hoe);
        in_valid = v; in_a = a; in_b = b; in_sum = s; halt_on_err = hoe;
    endtask

    // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after.
    task automatic cyc();
        bit rdy;
        bit acc;
        int gold;
        int s;
        @(negedge clk);
        rdy  = !m_halt && !clr && (!m_ov || out_ready);
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        acc  = in_valid && rdy;
        gold = int'(in_a) + int'(in_b);
        s    = int'(in_sum);
        @(posedge clk);
        if (acc) begin
            m_ov = 1; m_sum = s; m_err = (s != gold);
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (clr) begin
            m_txn = 0; m_ecnt = 0; m_sticky = 0; m_halt = 0; m_bmap = 0;
        end else if (acc) begin
            m_txn  = (m_txn + 1) % 16;
            m_bmap = m_bmap | (s ^ gold);
            if (s != gold) begin
                m_ecnt   = (m_ecnt < 15) ? m_ecnt + 1 : 15;
                m_sticky = 1;
                if (halt_on_err) m_halt = 1;
            end
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_sum", {27'b0, out_sum}, m_sum);
        chk("out_err", {31'b0, out_err}, {31'b0, m_err});
        chk("err_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
        chk("txn_cnt", {28'b0, txn_cnt}, m_txn);
        chk("err_cnt", {28'b0, err_cnt}, m_ecnt);
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
`ifdef ADDR4U_CHK_BITMAP_EN
        chk("err_bitmap", {27'b0, err_bitmap}, m_bmap);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_out_sum"}, {27'b0, out_sum}, 0);
        chk({tag, "_out_err"}, {31'b0, out_err}, 0);
        chk({tag, "_sticky"}, {31'b0, err_sticky}, 0);
        chk({tag, "_txn"}, {28'b0, txn_cnt}, 0);
        chk({tag, "_ecnt"}, {28'b0, err_cnt}, 0);
        chk({tag, "_halted"}, {31'b0, halted}, 0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 1);
`ifdef ADDR4U_CHK_BITMAP_EN
        chk({tag, "_bitmap"}, {27'b0, err_bitmap}, 0);
`endif
    endtask

    initial begin
        tbl[0] = '{4'hF, 4'h1, 5'h10, 1'b0};
        tbl[1] = '{4'h7, 4'h8, 5'h1F, 1'b1};
        tbl[2] = '{4'h0, 4'h0, 5'h00, 1'b0};
        tbl[3] = '{4'hF, 4'hF, 5'h1E, 1'b0};
        tbl[4] = '{4'hF, 4'hF, 5'h0E, 1'b1};
        tbl[5] = '{4'h3, 4'h5, 5'h08, 1'b0};
        tbl[6] = '{4'hA, 4'h5, 5'h0F, 1'b0};
        tbl[7] = '{4'h9, 4'h9, 5'h13, 1'b1};

        rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 5'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Directed table, full throughput, no halting.
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].sum, 1'b0);
            cyc();
            chk("tbl_out_err", {31'b0, out_err}, {31'b0, tbl[i].exp_err});
            chk("tbl_out_sum", {27'b0, out_sum}, {27'b0, tbl[i].sum});
`ifdef ADDR4U_CHK_BITMAP_EN
            if (i == 1) chk("tbl_bitmap", {27'b0, err_bitmap}, 32'h10);
`endif
        end

        // Halt on a mismatch, ignore further input, release with clr.
        drive(1'b1, 4'h7, 4'h8, 5'h1F, 1'b1);
        cyc();
        chk("halt_entered", {31'b0, halted}, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i), 4'h2, 5'(i + 2), 1'(i % 2));
            cyc();
        end
        chk("halt_held", {31'b0, halted}, 1);
        drive(1'b0, 4'h0, 4'h0, 5'h00, 1'b0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_txn", {28'b0, txn_cnt}, 0);
        chk("clr_halted", {31'b0, halted}, 0);
        cyc();

        // Backpressure: one accept, then stall, then one accept per cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 4'h3, 5'(i + 4), 1'b0);
            cyc();
        end
        chk("bp_held_sum", {27'b0, out_sum}, 32'h4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 5), 4'h1, 5'(i + 6), 1'b0);
            cyc();
        end

        // Saturation of err_cnt vs wrap of txn_cnt.
        drive(1'b0, 4'h0, 4'h0, 5'h00, 1'b0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 4'h1, 5'(i + 1) ^ 5'h01, 1'b0);
            cyc();
            if (i == 14) chk("sat_ecnt15", {28'b0, err_cnt}, 32'hF);
        end
        chk("sat_ecnt_hold", {28'b0, err_cnt}, 32'hF);
        chk("wrap_txn", {28'b0, txn_cnt}, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'($urandom);
            b = 4'($urandom);
            drive(($urandom % 4) != 0, a, b,
                  (($urandom % 2) != 0) ? ({1'b0, a} + {1'b0, b}) : 5'($urandom),
                  ($urandom % 8) == 0);
            clr       = ($urandom % 16) == 0;
            out_ready = ($urandom % 3) != 0;
            cyc();
        end
        clr = 1'b0;

        // Async reset while halted with a result pending.
        out_ready = 1'b0;
        drive(1'b1, 4'h7, 4'h8, 5'h1F, 1'b1);
        cyc();
        chk("pre_rst_halted", {31'b0, halted}, 1);
        chk("pre_rst_valid", {31'b0, out_valid}, 1);
        drive(1'b0, 4'h0, 4'h0, 5'h00, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        drive(1'b1, 4'h2, 4'h3, 5'h05, 1'b0);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
